// File: rtl/bnn_dense_layer.sv
// Binary dense (XNOR-popcount) layer: one score per output neuron, CHUNK input bits per cycle.
// Optional argmax tracking of class_out is enabled by defining BNN_DENSE_ARGMAX_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for data_in_ready; outputs hold last written values
// S_ACCUM | accumulating popcount of chunk k for neuron n
// S_STORE | writing acc into scores[n], updating argmax, next neuron
// S_DONE  | results valid, holding until data_in_ready drops
module bnn_dense_layer #(
    parameter int IC       = 8,
    parameter int IMG_SIZE = 14,
    parameter int OUT      = 10,
    parameter int CHUNK    = 196,
    localparam int PIX     = IMG_SIZE * IMG_SIZE,
    localparam int IN_BITS = IC * PIX,
    localparam int NCHUNK  = IN_BITS / CHUNK,
    localparam int SW      = $clog2(IN_BITS + 1),
    localparam int CW      = $clog2(OUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_in_ready,
    input  logic [PIX-1:0]     img_in  [0:IC-1],
    input  logic [IN_BITS-1:0] weights [0:OUT-1],
    output logic [SW-1:0]      scores  [0:OUT-1],
    output logic [CW-1:0]      class_out,
    output logic               data_out_ready
);

    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
    localparam logic [CW-1:0] N_LAST = CW'(OUT - 1);

    generate
        if (IN_BITS % CHUNK != 0) begin : g_chunk_check
            $error("bnn_dense_layer: IN_BITS must be divisible by CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_STORE, S_DONE} state_t;

    state_t             state;
    logic [KW-1:0]      k;
    logic [CW-1:0]      n;
    logic [SW-1:0]      acc;
    logic [IN_BITS-1:0] flat;
    logic [CHUNK-1:0]   chunk_xnor;
    logic [SW-1:0]      chunk_pop;

    function automatic logic [SW-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [SW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) cnt = cnt + SW'(v[i]);
        return cnt;
    endfunction

    always_comb begin
        flat = '0;
        for (int c = 0; c < IC; c++) flat[c*PIX +: PIX] = img_in[c];
    end

    assign chunk_xnor = ~(flat[k*CHUNK +: CHUNK] ^ weights[n][k*CHUNK +: CHUNK]);
    assign chunk_pop  = popcount(chunk_xnor);

`ifdef BNN_DENSE_ARGMAX_EN
    logic [SW-1:0] best;
`else
    assign class_out = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            k              <= '0;
            n              <= '0;
            acc            <= '0;
            data_out_ready <= 1'b0;
            for (int i = 0; i < OUT; i++) scores[i] <= '0;
`ifdef BNN_DENSE_ARGMAX_EN
            class_out      <= '0;
            best           <= '0;
`endif
        end else if (state != S_IDLE && !data_in_ready) begin
            // abort: scores and class_out deliberately keep their last values
            state          <= S_IDLE;
            k              <= '0;
            n              <= '0;
            acc            <= '0;
            data_out_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_in_ready) begin
                        acc   <= '0;
                        k     <= '0;
                        n     <= '0;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc + chunk_pop;
                    if (k == K_LAST) state <= S_STORE;
                    else             k     <= k + 1'b1;
                end
                S_STORE: begin
                    scores[n] <= acc;
`ifdef BNN_DENSE_ARGMAX_EN
                    // strict compare keeps the lowest index on ties
                    if (n == '0 || acc > best) begin
                        best      <= acc;
                        class_out <= n;
                    end
`endif
                    acc <= '0;
                    k   <= '0;
                    if (n == N_LAST) begin
                        state          <= S_DONE;
                        data_out_ready <= 1'b1;
                    end else begin
                        n     <= n + 1'b1;
                        state <= S_ACCUM;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_dense_layer.sv
// Self-checking bench for bnn_dense_layer: directed frames checked against a bit-level score model.
module tb_bnn_dense_layer;

    localparam int IC       = 8;
    localparam int IMG_SIZE = 14;
    localparam int OUT      = 10;
    localparam int CHUNK    = 196;
    localparam int PIX      = IMG_SIZE * IMG_SIZE;
    localparam int IN_BITS  = IC * PIX;
    localparam int SW       = $clog2(IN_BITS + 1);
    localparam int CW       = $clog2(OUT);
    localparam int LAT      = 1 + OUT * (IN_BITS / CHUNK + 1);

    logic               clk;
    logic               rst;
    logic               data_in_ready;
    logic [PIX-1:0]     img_in  [0:IC-1];
    logic [IN_BITS-1:0] weights [0:OUT-1];
    logic [SW-1:0]      scores  [0:OUT-1];
    logic [CW-1:0]      class_out;
    logic               data_out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_scores [0:OUT-1];
    int exp_class;

    bnn_dense_layer #(.IC(IC), .IMG_SIZE(IMG_SIZE), .OUT(OUT), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .data_in_ready(data_in_ready), .img_in(img_in),
        .weights(weights), .scores(scores), .class_out(class_out),
        .data_out_ready(data_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: count matching bits of the flattened input against each neuron's weights.
    task automatic compute_model();
        for (int n = 0; n < OUT; n++) begin
            int cnt = 0;
            for (int c = 0; c < IC; c++)
                for (int p = 0; p < PIX; p++)
                    if (img_in[c][p] == weights[n][c*PIX + p]) cnt++;
            exp_scores[n] = cnt;
        end
        exp_class = 0;
`ifdef BNN_DENSE_ARGMAX_EN
        for (int n = 1; n < OUT; n++)
            if (exp_scores[n] > exp_scores[exp_class]) exp_class = n;
`endif
    endtask

    task automatic set_flat(input logic [IN_BITS-1:0] fv);
        for (int c = 0; c < IC; c++) img_in[c] = fv[c*PIX +: PIX];
    endtask

    task automatic set_all_weights(input logic [IN_BITS-1:0] wv);
        for (int n = 0; n < OUT; n++) weights[n] = wv;
    endtask

    task automatic run_frame(input string name);
        int edges;
        compute_model();
        @(negedge clk);
        data_in_ready = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!data_out_ready && edges < 4 * LAT);
        chk({name, "_latency"}, edges, LAT);
    endtask

    task automatic drop_ready(input string name);
        @(negedge clk);
        data_in_ready = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_drop_dor"}, int'(data_out_ready), 0);
    endtask

    // Compare process: every cycle results are flagged valid, they must match the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (data_out_ready) begin
                for (int n = 0; n < OUT; n++) chk("cmp_score", int'(scores[n]), exp_scores[n]);
                chk("cmp_class", int'(class_out), exp_class);
            end
        end
    end

    initial begin
        logic [IN_BITS-1:0] fv;
        int tie_cls;

        rst = 1'b1;
        data_in_ready = 1'b0;
        set_flat('0);
        set_all_weights('0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dor", int'(data_out_ready), 0);
        chk("reset_class", int'(class_out), 0);
        for (int n = 0; n < OUT; n++) chk("reset_score", int'(scores[n]), 0);
        @(negedge clk);
        rst = 1'b0;

        // all zeros: every bit matches
        run_frame("zeros");
        chk("zeros_s0", int'(scores[0]), 1568);
        chk("zeros_s7", int'(scores[7]), 1568);
        chk("zeros_class", int'(class_out), 0);
        drop_ready("zeros");

        // all-ones image, only neuron 3 all ones
        set_flat('1);
        set_all_weights('0);
        weights[3] = '1;
        run_frame("ones");
        chk("ones_s3", int'(scores[3]), 1568);
        chk("ones_s0", int'(scores[0]), 0);
`ifdef BNN_DENSE_ARGMAX_EN
        chk("ones_class", int'(class_out), 3);
`endif
        drop_ready("ones");

        // chunk boundary bits
        set_flat('0);
        set_all_weights('0);
        weights[9][1567] = 1'b1;
        weights[4][195]  = 1'b1;
        weights[4][196]  = 1'b1;
        run_frame("bound");
        chk("bound_s9", int'(scores[9]), 1567);
        chk("bound_s4", int'(scores[4]), 1566);
        chk("bound_s5", int'(scores[5]), 1568);
        drop_ready("bound");

        // tie between neurons 2 and 5
        for (int i = 0; i < IN_BITS; i++) fv[i] = ((i * 7) % 5) < 2;
        set_flat(fv);
        set_all_weights(~fv);
        weights[2] = fv;
        weights[5] = fv;
        run_frame("tie");
        chk("tie_s2", int'(scores[2]), 1568);
        chk("tie_s5", int'(scores[5]), 1568);
        chk("tie_s4", int'(scores[4]), 0);
`ifdef BNN_DENSE_ARGMAX_EN
        tie_cls = 2;
`else
        tie_cls = 0;
`endif
        chk("tie_class", int'(class_out), tie_cls);

        // hold past DONE: no re-run, outputs stable (compare process checks values)
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("hold_dor", int'(data_out_ready), 1);
        end
        drop_ready("hold");
        for (int i = 0; i < IN_BITS; i++) fv[i] = (i % 3) == 0;
        set_flat(fv);
        run_frame("hold_new");
        drop_ready("hold_new");

        // abort at edge 40, then full re-run
        compute_model();
        @(negedge clk);
        data_in_ready = 1'b1;
        repeat (39) @(posedge clk);
        @(negedge clk);
        data_in_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("abort_dor", int'(data_out_ready), 0);
        end
        run_frame("abort_rerun");
        drop_ready("abort_rerun");

        // synchronous reset at edge 50
        @(negedge clk);
        data_in_ready = 1'b1;
        repeat (49) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_dor", int'(data_out_ready), 0);
        chk("rst_class", int'(class_out), 0);
        for (int n = 0; n < OUT; n++) chk("rst_score", int'(scores[n]), 0);
        @(negedge clk);
        rst = 1'b0;
        data_in_ready = 1'b0;
        @(posedge clk);

        set_flat('0);
        set_all_weights('0);
        weights[6] = '0;
        weights[6][0] = 1'b1;
        run_frame("post_rst");
        chk("post_rst_s6", int'(scores[6]), 1567);
        drop_ready("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
